// File: rtl/spio_aer2spinn_pkg.sv
// rtl/spio_aer2spinn_pkg.sv - shared constants, packet layout and coordinate mapping for the AER-to-SpiNNaker mapper
package spio_aer2spinn_pkg;

    localparam int MODE_BITS  = 3;
    localparam int VCRD_BITS  = 16;
    localparam int COORD_BITS = 16;
    localparam int KEY_BITS   = 32;
    localparam int PL_BITS    = 32;
    localparam int PKT_BITS   = 72;

    // Packet field positions
    localparam int KEY_LSB   = 8;
    localparam int PL_LSB    = 40;
    localparam int PLF_BIT   = 1;
    localparam int PAR_BIT   = 0;
    localparam int NOPL_BITS = 40;

    typedef enum logic [MODE_BITS-1:0] {
        MODE_RET_128 = 3'd0,
        MODE_RET_64  = 3'd1,
        MODE_RET_32  = 3'd2,
        MODE_RET_16  = 3'd3,
        MODE_COCHLEA = 3'd4,
        MODE_DIRECT  = 3'd5
    } mode_e;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_WTRQ = 1'b1
    } ch_state_e;

    // Sensor event to 16-bit routing coordinate; unused mode codes fall back to RET_128.
    function automatic logic [COORD_BITS-1:0] map_coords(
        input logic [MODE_BITS-1:0]  mode,
        input logic [COORD_BITS-1:0] d
    );
        logic [6:0] new_x;
        logic [6:0] new_y;
        logic [COORD_BITS-1:0] res;
        new_x = 7'd127 - d[14:8];
        new_y = 7'd127 - d[7:1];
        case (mode)
            MODE_RET_64:  res = {d[15], d[0], 2'b0, new_y[6:1], new_x[6:1]};
            MODE_RET_32:  res = {d[15], d[0], 4'b0, new_y[6:2], new_x[6:2]};
            MODE_RET_16:  res = {d[15], d[0], 6'b0, new_y[6:3], new_x[6:3]};
            MODE_COCHLEA: res = {d[15], 3'b0, d[1], 3'b0, d[7:2], d[9:8]};
            MODE_DIRECT:  res = d;
            default:      res = {d[15], d[0], new_y, new_x};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spio_aer2spinn_fifo.sv
// rtl/spio_aer2spinn_fifo.sv - first-word-fall-through FIFO with registered output, full flag and level
module spio_aer2spinn_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_vld,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [LW-1:0]    count;
    logic [LW-1:0]    remain;
    logic             push;
    logic             pop;

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a write.
    assign full     = (count == LW'(DEPTH));
    assign pop      = rd_en && rd_vld;
    assign push     = wr_en && (!full || pop);
    assign rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    // Entries that existed before this edge and survive it; a same-edge write shows up one cycle later.
    assign remain   = count - LW'(pop);
    assign level    = count;

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head-of-queue output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_n;
            count  <= count + LW'(push) - LW'(pop);
            rd_vld <= (remain != '0);
            if (remain != '0) begin
                rd_data <= mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/spio_aer2spinn_mc_mapper.sv
// rtl/spio_aer2spinn_mc_mapper.sv - multi-channel AER to SpiNNaker multicast mapper; SPIO_AER2SPINN_TS_EN adds timestamp payloads
module spio_aer2spinn_mc_mapper
    import spio_aer2spinn_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MODE_BITS-1:0]          mode,
    input  logic [VCRD_BITS-1:0]          vcoord,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH*16-1:0]          iaer_data,
    input  logic [NUM_CH-1:0]             iaer_req,
    output logic [NUM_CH-1:0]             iaer_ack,
    output logic [PKT_BITS-1:0]           ipkt_data,
    output logic                          ipkt_vld,
    input  logic                          ipkt_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl
);

    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef SPIO_AER2SPINN_TS_EN
    localparam int FW = PKT_BITS;
`else
    localparam int FW = NOPL_BITS;
`endif

    ch_state_e           ch_state [NUM_CH];
    logic [CH_BITS-1:0]  last_grant;
    logic [CH_BITS-1:0]  gnt_ch;
    logic [CH_BITS-1:0]  cand;
    logic                gnt_vld;
    logic [NUM_CH-1:0]   elig;
    logic                fifo_full;
    logic                pkt_pop;
    logic                can_push;
    logic [15:0]         sel_data;
    logic [KEY_BITS-1:0] key;
    logic [PL_BITS-1:0]  payload;
    logic                pl_flag;
    logic [PKT_BITS-1:0] pkt;
    logic [FW-1:0]       fifo_rd_data;

    assign pkt_pop  = ipkt_vld && ipkt_rdy;
    assign can_push = !fifo_full || pkt_pop;

`ifdef SPIO_AER2SPINN_TS_EN
    logic [PL_BITS-1:0] ts_cnt;

    // Free-running cycle counter sampled into each packet at its grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    assign payload   = ts_cnt;
    assign pl_flag   = 1'b1;
    assign ipkt_data = fifo_rd_data;
`else
    assign payload   = '0;
    assign pl_flag   = 1'b0;
    assign ipkt_data = {{(PKT_BITS - FW){1'b0}}, fifo_rd_data};
`endif

    // A channel may be granted only when idle, requesting, enabled and the FIFO can take the event.
    always_comb begin
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = (ch_state[c] == CH_IDLE) && !iaer_req[c] && ch_en[c] && can_push;
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        cand    = last_grant;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == CH_BITS'(NUM_CH - 1)) ? '0 : cand + 1'b1;
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    // Route the granted channel's event data to the packet builder.
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_ch == CH_BITS'(c)) begin
                sel_data = iaer_data[c*16 +: 16];
            end
        end
    end

    // Build the packet from the current mode/vcoord, so the grant edge is what samples them.
    always_comb begin
        key                         = {vcoord + VCRD_BITS'(gnt_ch), map_coords(mode, sel_data)};
        pkt                         = '0;
        pkt[PL_LSB +: PL_BITS]      = payload;
        pkt[KEY_LSB +: KEY_BITS]    = key;
        pkt[PLF_BIT]                = pl_flag;
        pkt[PAR_BIT]                = ~(^pkt[PKT_BITS-1:1]);
    end

    // Per-channel 4-phase handshake FSMs and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= CH_BITS'(NUM_CH - 1);
            iaer_ack   <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_state[c] <= CH_IDLE;
            end
        end else begin
            if (gnt_vld) begin
                last_grant <= gnt_ch;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                case (ch_state[c])
                    CH_IDLE: begin
                        if (gnt_vld && (gnt_ch == CH_BITS'(c))) begin
                            ch_state[c] <= CH_WTRQ;
                            iaer_ack[c] <= 1'b0;
                        end
                    end
                    CH_WTRQ: begin
                        if (iaer_req[c]) begin
                            ch_state[c] <= CH_IDLE;
                            iaer_ack[c] <= 1'b1;
                        end
                    end
                    default: begin
                        ch_state[c] <= CH_IDLE;
                        iaer_ack[c] <= 1'b1;
                    end
                endcase
            end
        end
    end

    spio_aer2spinn_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (gnt_vld),
        .wr_data (pkt[FW-1:0]),
        .full    (fifo_full),
        .rd_en   (ipkt_rdy),
        .rd_data (fifo_rd_data),
        .rd_vld  (ipkt_vld),
        .level   (fifo_lvl)
    );

endmodule
